ram_port_arbiter: RTL

// - Shares one single-port 8-bit RAM between two requesters (A, B) on a single clock.
// - Replaces the two-clock, two-port access pattern with one registered RAM port.
// - Round-robin arbitration, write-through read-data registers, 1-cycle read latency.
// - Sits between two bus-side masters and the memory macro.

---
 rtl/ram_port_arbiter_pkg.sv | 13 +
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter_sp_ram.sv | 24 ++
 rtl/ram_port_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, port selector and request record for the RAM port arbiter.
package ram_arb_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} port_sel_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for the two requester ports of the RAM arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_q;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_q;

  // requester side
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_q, b_gnt, b_rvalid, b_q
  );

  // arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_q, b_gnt, b_rvalid, b_q
  );
endinterface

// File: rtl/ram_port_arbiter_sp_ram.sv
// Single-port RAM: synchronous write, registered read, storage not reset.
module sp_ram
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // one access per cycle; read data register only updates on reads
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between ports A and B.
// Read data reaches a port's q one cycle after its grant by steering the RAM
// read register straight to that port while its rvalid is high, then latching
// it into the port's own q register so q holds until the port's next grant.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int ADDR_W = ram_arb_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  port_sel_e         ptr;
  logic              a_gnt, b_gnt, ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q, a_q_r, b_q_r;
  logic              a_rv, b_rv;

  // grant: lone requester wins, contention goes to the pointer; nothing in reset
  always_comb begin
    a_gnt = rst_n & bus.a_req & (~bus.b_req | (ptr == SEL_A));
    b_gnt = rst_n & bus.b_req & ~a_gnt;
  end

  // steer the granted port's request onto the RAM
  always_comb begin
    ram_en    = a_gnt | b_gnt;
    ram_we    = a_gnt ? bus.a_we    : bus.b_we;
    ram_addr  = a_gnt ? bus.a_addr  : bus.b_addr;
    ram_wdata = a_gnt ? bus.a_wdata : bus.b_wdata;
  end

  sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // pointer, read-valid pulses (double as last-grant selector) and q registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= SEL_A;
      a_rv  <= 1'b0;
      b_rv  <= 1'b0;
      a_q_r <= '0;
      b_q_r <= '0;
    end else begin
      a_rv <= a_gnt & ~bus.a_we;
      b_rv <= b_gnt & ~bus.b_we;
      if (a_gnt)      ptr <= SEL_B;
      else if (b_gnt) ptr <= SEL_A;
      // capture a completed read; a write-through on the same edge overrides it
      if (a_rv)                a_q_r <= ram_q;
      if (a_gnt && bus.a_we)   a_q_r <= bus.a_wdata;
      if (b_rv)                b_q_r <= ram_q;
      if (b_gnt && bus.b_we)   b_q_r <= bus.b_wdata;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rv;
  assign bus.b_rvalid = b_rv;
  assign bus.a_q      = a_rv ? ram_q : a_q_r;
  assign bus.b_q      = b_rv ? ram_q : b_q_r;
endmodule
